// File: rtl/ser_rx_pkg.sv
// Shared definitions for the serial receive sequencer: byte width default,
// receive state encoding and bit-counter width.
package ser_rx_pkg;

   localparam int unsigned BYTE_W_DEF = 8;
   localparam int unsigned CNT_W      = $clog2(BYTE_W_DEF);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } rx_state_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers; the output holds the last
// popped byte while empty.
module rx_byte_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned BYTE_W = 8
) (
   input  logic                       inv_serclk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [BYTE_W-1:0]          push_data,
   input  logic                       pop,
   output logic [BYTE_W-1:0]          pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]         r_wptr;
   logic [AW:0]         r_rptr;
   logic [BYTE_W-1:0]   r_mem [DEPTH];
   logic [BYTE_W-1:0]   r_hold;
   logic                w_do_pop;
   logic                w_do_push;

   assign empty     = (r_wptr == r_rptr);
   assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign level     = r_wptr - r_rptr;
   assign w_do_pop  = pop & ~empty;
   // A push into a full FIFO still succeeds when a pop frees a slot this edge.
   assign w_do_push = push & (~full | w_do_pop);
   assign pop_data  = empty ? r_hold : r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge inv_serclk or posedge reset) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_hold <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop) begin
            r_rptr <= r_rptr + 1'b1;
            r_hold <= r_mem[r_rptr[AW-1:0]];
         end
      end
   end

   always_ff @(posedge inv_serclk) begin
      if (w_do_push) r_mem[r_wptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/ser_rx_ctrl.sv
// Receive sequencer for the serial shift-in register: shift enable, bit
// counting, byte capture into a FIFO, and sticky truncation/overflow status.
module ser_rx_ctrl
   import ser_rx_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned BYTE_W = BYTE_W_DEF
) (
   input  logic                         inv_serclk,
   input  logic                         reset,
   input  logic                         cs_n,
   input  logic [BYTE_W-1:0]            sr_data,
   output logic                         sr_enable,
   output logic [BYTE_W-1:0]            rd_data,
   output logic                         rd_valid,
   input  logic                         rd_ready,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
   output logic                         overflow,
   output logic                         frame_err,
   input  logic                         clr_status
);

   localparam int unsigned CW = $clog2(BYTE_W);

   rx_state_t        r_state;
   rx_state_t        w_state_nxt;
   logic [CW-1:0]    r_bit_cnt;
   logic             r_byte_done;
   logic             r_overflow;
   logic             r_frame_err;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_ovf_set;
   logic             w_ferr_set;

   assign sr_enable = ~cs_n;
   assign rd_valid  = ~w_empty;
   assign w_pop     = ~w_empty & rd_ready;
   assign overflow  = r_overflow;
   assign frame_err = r_frame_err;

   always_ff @(posedge inv_serclk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ferr_set  = 1'b0;
      w_ovf_set   = r_byte_done & w_full & ~w_pop;
      case (r_state)
         IDLE:   if (!cs_n) w_state_nxt = ACTIVE;
         ACTIVE: begin
            if (cs_n) begin
               w_state_nxt = IDLE;
               w_ferr_set  = (r_bit_cnt != '0);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge inv_serclk or posedge reset) begin
      if (reset) begin
         r_bit_cnt   <= '0;
         r_byte_done <= 1'b0;
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_byte_done <= sr_enable && (r_bit_cnt == CW'(BYTE_W - 1));
         if (sr_enable) r_bit_cnt <= r_bit_cnt + 1'b1;
         else           r_bit_cnt <= '0;
         // Setting wins over a simultaneous clear.
         if (w_ovf_set)       r_overflow <= 1'b1;
         else if (clr_status) r_overflow <= 1'b0;
         if (w_ferr_set)      r_frame_err <= 1'b1;
         else if (clr_status) r_frame_err <= 1'b0;
      end
   end

   rx_byte_fifo #(
      .DEPTH  (DEPTH),
      .BYTE_W (BYTE_W)
   ) u_fifo (
      .inv_serclk (inv_serclk),
      .reset      (reset),
      .push       (r_byte_done),
      .push_data  (sr_data),
      .pop        (w_pop),
      .pop_data   (rd_data),
      .full       (w_full),
      .empty      (w_empty),
      .level      (fifo_level)
   );

endmodule

// File: tb/tb_ser_rx_ctrl.sv
// Randomized bench for ser_rx_ctrl against a queue-based reference model of
// frames, bytes, FIFO occupancy and sticky status.
module tb_ser_rx_ctrl;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned BYTE_W = 8;

   logic                inv_serclk = 1'b0;
   logic                reset;
   logic                cs_n;
   logic [BYTE_W-1:0]   sr_data;
   logic                sr_enable;
   logic [BYTE_W-1:0]   rd_data;
   logic                rd_valid;
   logic                rd_ready;
   logic [2:0]          fifo_level;
   logic                overflow;
   logic                frame_err;
   logic                clr_status;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   // Emulated shift register feeding sr_data.
   logic [BYTE_W-1:0]   sr_emul;

   // Reference model state.
   logic [BYTE_W-1:0]   m_q[$];
   logic [BYTE_W-1:0]   m_last;
   logic [BYTE_W-1:0]   m_pend_val;
   logic                m_pend;
   int unsigned         m_bits;
   logic                m_ovf;
   logic                m_ferr;

   ser_rx_ctrl #(
      .DEPTH  (DEPTH),
      .BYTE_W (BYTE_W)
   ) dut (
      .inv_serclk (inv_serclk),
      .reset      (reset),
      .cs_n       (cs_n),
      .sr_data    (sr_data),
      .sr_enable  (sr_enable),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .frame_err  (frame_err),
      .clr_status (clr_status)
   );

   always #5 inv_serclk = ~inv_serclk;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_last     = '0;
      m_pend     = 1'b0;
      m_pend_val = '0;
      m_bits     = 0;
      m_ovf      = 1'b0;
      m_ferr     = 1'b0;
   endtask

   // One edge of the model; sr_emul already includes this edge's shift.
   task automatic m_step(input logic cs, input logic rdy, input logic clr);
      logic pop;
      logic ovs;
      logic fes;
      pop = (m_q.size() != 0) && rdy;
      ovs = 1'b0;
      fes = 1'b0;
      if (pop) m_last = m_q.pop_front();
      if (m_pend) begin
         if (m_q.size() < DEPTH) m_q.push_back(m_pend_val);
         else                    ovs = 1'b1;
      end
      if (!cs) begin
         m_bits++;
         if (m_bits == BYTE_W) begin
            m_pend     = 1'b1;
            m_pend_val = sr_emul;
            m_bits     = 0;
         end else begin
            m_pend = 1'b0;
         end
      end else begin
         fes    = (m_bits != 0);
         m_bits = 0;
         m_pend = 1'b0;
      end
      if (ovs)      m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (fes)      m_ferr = 1'b1;
      else if (clr) m_ferr = 1'b0;
   endtask

   task automatic check_outputs();
      logic [BYTE_W-1:0] exp_data;
      exp_data = (m_q.size() != 0) ? m_q[0] : m_last;
      chk_val("rd_valid",   32'(rd_valid),   32'(m_q.size() != 0));
      chk_val("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      chk_val("overflow",   32'(overflow),   32'(m_ovf));
      chk_val("frame_err",  32'(frame_err),  32'(m_ferr));
      chk_val("rd_data",    32'(rd_data),    32'(exp_data));
   endtask

   // Called just after a falling edge; applies inputs for the next active edge.
   task automatic tick(input logic cs, input logic b, input logic rdy, input logic clr);
      cs_n       = cs;
      rd_ready   = rdy;
      clr_status = clr;
      sr_data    = sr_emul;
      #1;
      chk_val("sr_enable", 32'(sr_enable), 32'(!cs));
      @(posedge inv_serclk);
      if (!cs) sr_emul = {sr_emul[BYTE_W-2:0], b};
      if (reset) m_reset();
      else       m_step(cs, rdy, clr);
      @(negedge inv_serclk);
      check_outputs();
   endtask

   task automatic send_bits(input logic [BYTE_W-1:0] v, input int unsigned n, input logic rdy);
      for (int unsigned i = 0; i < n; i++) tick(1'b0, v[BYTE_W-1-i], rdy, 1'b0);
   endtask

   task automatic idle(input int unsigned n, input logic rdy);
      for (int unsigned i = 0; i < n; i++) tick(1'b1, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      logic cs;
      logic rdy;
      int unsigned rdy_pct;

      reset      = 1'b1;
      cs_n       = 1'b1;
      rd_ready   = 1'b0;
      clr_status = 1'b0;
      sr_emul    = '0;
      sr_data    = '0;
      m_reset();
      @(negedge inv_serclk);
      check_outputs();
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      // Two-byte frame streamed to a ready consumer.
      send_bits(8'hA5, 8, 1'b1);
      send_bits(8'h3C, 8, 1'b1);
      idle(3, 1'b1);
      chk_val("t1_flags", 32'({overflow, frame_err}), 32'd0);

      // Truncated frame then a clean byte.
      send_bits(8'($urandom), 8, 1'b1);
      send_bits(8'($urandom), 3, 1'b1);
      idle(2, 1'b1);
      chk_val("t2_frame_err", 32'(frame_err), 32'd1);
      tick(1'b1, 1'b0, 1'b1, 1'b1);
      send_bits(8'($urandom), 8, 1'b1);
      idle(3, 1'b1);

      // Overflow with a stalled consumer, then drain.
      for (int unsigned i = 0; i < 5; i++) send_bits(8'($urandom), 8, 1'b0);
      idle(2, 1'b0);
      chk_val("t3_level", 32'(fifo_level), 32'd4);
      chk_val("t3_ovf", 32'(overflow), 32'd1);
      idle(6, 1'b1);
      tick(1'b1, 1'b0, 1'b0, 1'b1);

      // Full FIFO, pop coinciding with the push edge.
      for (int unsigned i = 0; i < 4; i++) send_bits(8'($urandom), 8, 1'b0);
      send_bits(8'($urandom), 8, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      chk_val("t4_level", 32'(fifo_level), 32'd4);
      chk_val("t4_ovf", 32'(overflow), 32'd0);

      // Clear coinciding with a fresh overflow, then clear alone.
      send_bits(8'($urandom), 8, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      chk_val("t5_ovf_hold", 32'(overflow), 32'd1);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      chk_val("t5_ovf_clr", 32'(overflow), 32'd0);
      idle(6, 1'b1);

      // Reset mid-byte with bytes queued; frame continues after release.
      send_bits(8'($urandom), 8, 1'b0);
      send_bits(8'($urandom), 8, 1'b0);
      send_bits(8'($urandom), 3, 1'b1);
      send_bits(8'($urandom), 4, 1'b0);
      reset = 1'b1;
      #1;
      m_reset();
      check_outputs();
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      reset = 1'b0;
      send_bits(8'($urandom), 8, 1'b1);
      idle(3, 1'b1);
      chk_val("t6_ferr", 32'(frame_err), 32'd0);

      // Random frames, consumer throttling and status clears.
      cs = 1'b1;
      for (int unsigned blk = 0; blk < 40; blk++) begin
         rdy_pct = $urandom_range(0, 10);
         for (int unsigned i = 0; i < 64; i++) begin
            if ($urandom_range(0, 11) == 0) cs = ~cs;
            rdy = ($urandom_range(0, 9) < rdy_pct);
            tick(cs, 1'($urandom_range(0, 1)), rdy, ($urandom_range(0, 19) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
